// File: rtl/layer_serializer.sv
// Gathers one output per neuron (in any order, any skew) and replays the
// completed frame as a serial stream, element 0 first, one per clock.
module layer_serializer #(
    parameter int NN        = 30,
    parameter int dataWidth = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NN-1:0]           i_valid,
    input  logic [NN*dataWidth-1:0] i_data,
    output logic                    o_valid,
    output logic [dataWidth-1:0]    o_data,
    output logic                    o_last,
    output logic                    busy,
    output logic                    overrun
);

    localparam int CW = (NN > 1) ? $clog2(NN) : 1;
    localparam logic [CW-1:0] LAST = CW'(NN - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                 state_q, state_d;
    logic [NN-1:0]          mask_q, mask_d;
    logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
    logic [dataWidth-1:0]   o_data_q, o_data_d;
    logic                   o_valid_q, o_valid_d;
    logic                   o_last_q, o_last_d;
    logic                   overrun_q, overrun_d;
    logic                   full, xfer;

    logic [dataWidth-1:0]   coll_q  [NN];
    logic [dataWidth-1:0]   shbuf_q [NN];

    always_comb begin
        full      = &mask_q;
        // A frame moves out of the collect buffer only when the sender is free
        // or is presenting its final element right now.
        xfer      = full && ((state_q == IDLE) || (cnt_q == LAST));
        cnt_inc   = cnt_q + CW'(1);

        state_d   = state_q;
        cnt_d     = cnt_q;
        o_data_d  = o_data_q;
        o_valid_d = o_valid_q;
        o_last_d  = o_last_q;
        mask_d    = xfer ? i_valid : (mask_q | i_valid);
        overrun_d = overrun_q | ((|(i_valid & mask_q)) && !xfer);

        if (xfer) begin
            state_d   = SEND;
            cnt_d     = '0;
            o_valid_d = 1'b1;
            o_last_d  = 1'b0;
            o_data_d  = coll_q[0];
        end else if (state_q == SEND) begin
            if (cnt_q == LAST) begin
                state_d   = IDLE;
                o_valid_d = 1'b0;
                o_last_d  = 1'b0;
            end else begin
                cnt_d    = cnt_inc;
                o_data_d = shbuf_q[cnt_inc];
                o_last_d = (cnt_inc == LAST);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            cnt_q     <= '0;
            o_data_q  <= '0;
            o_valid_q <= 1'b0;
            o_last_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            cnt_q     <= cnt_d;
            o_data_q  <= o_data_d;
            o_valid_q <= o_valid_d;
            o_last_q  <= o_last_d;
            overrun_q <= overrun_d;
        end
    end

    // Data storage carries no reset; the mask alone decides what is valid.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NN; k++) begin
            if (i_valid[k] && (xfer || !mask_q[k])) begin
                coll_q[k] <= i_data[k*dataWidth +: dataWidth];
            end
        end
        if (xfer) begin
            shbuf_q <= coll_q;
        end
    end

    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;
    assign o_last  = o_last_q;
    assign busy    = (state_q == SEND);
    assign overrun = overrun_q;

endmodule
